// File: rtl/ex_hilo_div_pkg.sv
// Shared operator/category codes and divider state encodings for the
// execute stage with HI/LO registers and an iterative divider.
package ex_hilo_div_pkg;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;
   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   // Codes occupy the low bits of the operator/category buses.
   typedef logic [7:0] op_t;
   typedef logic [2:0] cat_t;

   localparam cat_t CAT_NOP    = 3'd0;
   localparam cat_t CAT_LOGIC  = 3'd1;
   localparam cat_t CAT_SHIFT  = 3'd2;
   localparam cat_t CAT_ARITH  = 3'd3;
   localparam cat_t CAT_MOVE   = 3'd4;
   localparam cat_t CAT_MULDIV = 3'd5;

   localparam op_t OP_NOP   = 8'h00;
   localparam op_t OP_AND   = 8'h01;
   localparam op_t OP_OR    = 8'h02;
   localparam op_t OP_XOR   = 8'h03;
   localparam op_t OP_NOR   = 8'h04;
   localparam op_t OP_LUI   = 8'h05;
   localparam op_t OP_SLL   = 8'h08;
   localparam op_t OP_SRL   = 8'h09;
   localparam op_t OP_SRA   = 8'h0A;
   localparam op_t OP_ADD   = 8'h10;
   localparam op_t OP_ADDU  = 8'h11;
   localparam op_t OP_SUB   = 8'h12;
   localparam op_t OP_SUBU  = 8'h13;
   localparam op_t OP_SLT   = 8'h14;
   localparam op_t OP_SLTU  = 8'h15;
   localparam op_t OP_MFHI  = 8'h18;
   localparam op_t OP_MFLO  = 8'h19;
   localparam op_t OP_MTHI  = 8'h1A;
   localparam op_t OP_MTLO  = 8'h1B;
   localparam op_t OP_MULT  = 8'h20;
   localparam op_t OP_MULTU = 8'h21;
   localparam op_t OP_MUL   = 8'h22;
   localparam op_t OP_DIV   = 8'h23;
   localparam op_t OP_DIVU  = 8'h24;

   typedef logic [1:0] div_state_t;
   localparam div_state_t DIV_IDLE = 2'd0;
   localparam div_state_t DIV_BUSY = 2'd1;
   localparam div_state_t DIV_DONE = 2'd2;

endpackage

// File: rtl/ex_hilo_div_div_unit.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes,
// signs re-applied on the way out.
module div_unit
   import ex_hilo_div_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  signed_mode,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   input  logic                  annul,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder
);

   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);

   div_state_t            state_q, state_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [DATA_WIDTH-1:0] quo_q, quo_d;
   logic [DATA_WIDTH-1:0] rem_q, rem_d;
   logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
   logic                  neg_quo_q, neg_quo_d;
   logic                  neg_rem_q, neg_rem_d;
   logic [DATA_WIDTH:0]   rem_shift, trial;
   logic                  dividend_neg, divisor_neg;

   assign dividend_neg = signed_mode & dividend[DATA_WIDTH-1];
   assign divisor_neg  = signed_mode & divisor[DATA_WIDTH-1];
   // Partial remainder stays below the divisor, so one extra bit holds the sign of the trial.
   assign rem_shift    = {rem_q, quo_q[DATA_WIDTH-1]};
   assign trial        = rem_shift - {1'b0, dvs_q};

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path infers a latch.
      state_d   = state_q;
      count_d   = count_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      case (state_q)
         DIV_IDLE: begin
            if (start) begin
               state_d   = DIV_BUSY;
               count_d   = '0;
               quo_d     = dividend_neg ? -dividend : dividend;
               rem_d     = '0;
               dvs_d     = divisor_neg ? -divisor : divisor;
               neg_quo_d = dividend_neg ^ divisor_neg;
               neg_rem_d = dividend_neg;
            end
         end
         DIV_BUSY: begin
            if (trial[DATA_WIDTH]) begin
               rem_d = rem_shift[DATA_WIDTH-1:0];
               quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
            end else begin
               rem_d = trial[DATA_WIDTH-1:0];
               quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
            end
            count_d = count_q + 1'b1;
            if (count_q == LAST_STEP) state_d = DIV_DONE;
         end
         DIV_DONE: state_d = DIV_IDLE;
         default:  state_d = DIV_IDLE;
      endcase
      if (annul) state_d = DIV_IDLE;
   end

   // NOTE: state registers use non-blocking assignments so all update together at the edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= DIV_IDLE;
         count_q   <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   assign busy      = !annul && (((state_q == DIV_IDLE) && start) || (state_q == DIV_BUSY));
   assign done      = !annul && (state_q == DIV_DONE);
   assign quotient  = neg_quo_q ? -quo_q : quo_q;
   assign remainder = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_hilo_div.sv
// MIPS execute stage: combinational logic/shift/arith/move/multiply results,
// architectural HI/LO registers and a stalling iterative divider.
module ex_hilo_div
   import ex_hilo_div_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int OP_WIDTH   = 8,
   parameter int CAT_WIDTH  = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [OP_WIDTH-1:0]   operator,
   input  logic [CAT_WIDTH-1:0]  category,
   input  logic [DATA_WIDTH-1:0] operand1,
   input  logic [DATA_WIDTH-1:0] operand2,
   input  logic [ADDR_WIDTH-1:0] input_write_addr,
   input  logic                  input_write_enable,
   input  logic                  flush,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic                  write_enable,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic                  stall_request
);

   localparam int MSB     = DATA_WIDTH - 1;
   localparam int HALF    = DATA_WIDTH / 2;
   localparam int SHAMT_W = $clog2(DATA_WIDTH);

   op_t                     op;
   cat_t                    cat;
   logic [SHAMT_W-1:0]      shamt;
   logic [DATA_WIDTH-1:0]   sum, diff, sra_res;
   logic                    add_ovf, sub_ovf, slt, sltu;
   logic [2*DATA_WIDTH-1:0] prod_s, prod_u;
   logic [DATA_WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [DATA_WIDTH-1:0]   result;
   logic                    wen_ok;
   logic                    is_div, div_start, div_busy, div_done;
   logic [DATA_WIDTH-1:0]   div_quotient, div_remainder;

   assign op    = op_t'(operator);
   assign cat   = cat_t'(category);
   assign shamt = operand1[SHAMT_W-1:0];

   assign sum     = operand1 + operand2;
   assign diff    = operand1 - operand2;
   assign add_ovf = (operand1[MSB] == operand2[MSB]) && (sum[MSB] != operand1[MSB]);
   assign sub_ovf = (operand1[MSB] != operand2[MSB]) && (diff[MSB] != operand1[MSB]);
   assign slt     = $signed(operand1) < $signed(operand2);
   assign sltu    = operand1 < operand2;
   assign sra_res = $signed(operand2) >>> shamt;

   assign prod_s = {{DATA_WIDTH{operand1[MSB]}}, operand1} * {{DATA_WIDTH{operand2[MSB]}}, operand2};
   assign prod_u = {{DATA_WIDTH{1'b0}}, operand1} * {{DATA_WIDTH{1'b0}}, operand2};

   assign is_div    = (cat == CAT_MULDIV) && ((op == OP_DIV) || (op == OP_DIVU));
   assign div_start = is_div && (operand2 != '0);

   div_unit #(.DATA_WIDTH(DATA_WIDTH)) u_div (
      .clock       (clock),
      .reset       (reset),
      .start       (div_start),
      .signed_mode (op == OP_DIV),
      .dividend    (operand1),
      .divisor     (operand2),
      .annul       (flush),
      .busy        (div_busy),
      .done        (div_done),
      .quotient    (div_quotient),
      .remainder   (div_remainder)
   );

   always_comb begin
      result = '0;
      wen_ok = ENABLE;
      case (cat)
         CAT_LOGIC: begin
            case (op)
               OP_AND:  result = operand1 & operand2;
               OP_OR:   result = operand1 | operand2;
               OP_XOR:  result = operand1 ^ operand2;
               OP_NOR:  result = ~(operand1 | operand2);
               OP_LUI:  result = {operand2[HALF-1:0], {HALF{1'b0}}};
               default: result = '0;
            endcase
         end
         CAT_SHIFT: begin
            case (op)
               OP_SLL:  result = operand2 << shamt;
               OP_SRL:  result = operand2 >> shamt;
               OP_SRA:  result = sra_res;
               default: result = '0;
            endcase
         end
         CAT_ARITH: begin
            case (op)
               OP_ADD:  begin result = sum;  wen_ok = !add_ovf; end
               OP_ADDU: result = sum;
               OP_SUB:  begin result = diff; wen_ok = !sub_ovf; end
               OP_SUBU: result = diff;
               OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, slt};
               OP_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, sltu};
               default: result = '0;
            endcase
         end
         CAT_MOVE: begin
            case (op)
               OP_MFHI:          result = hi_q;
               OP_MFLO:          result = lo_q;
               OP_MTHI, OP_MTLO: wen_ok = DISABLE;
               default:          result = '0;
            endcase
         end
         CAT_MULDIV: begin
            case (op)
               OP_MUL:           result = prod_s[DATA_WIDTH-1:0];
               OP_DIV, OP_DIVU:  wen_ok = DISABLE;
               default:          result = '0;
            endcase
         end
         default: result = '0;
      endcase
   end

   // A finished divide owns HI/LO; otherwise a flushed instruction leaves them alone.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (div_done) begin
         hi_d = div_remainder;
         lo_d = div_quotient;
      end else if (!flush) begin
         if ((cat == CAT_MOVE) && (op == OP_MTHI)) hi_d = operand1;
         if ((cat == CAT_MOVE) && (op == OP_MTLO)) lo_d = operand1;
         if ((cat == CAT_MULDIV) && (op == OP_MULT))  {hi_d, lo_d} = prod_s;
         if ((cat == CAT_MULDIV) && (op == OP_MULTU)) {hi_d, lo_d} = prod_u;
         if (is_div && (operand2 == '0)) begin
            hi_d = '0;
            lo_d = '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign write_addr    = reset ? '0 : input_write_addr;
   assign write_enable  = !reset && input_write_enable && wen_ok;
   assign write_data    = reset ? '0 : result;
   assign stall_request = !reset && div_busy;

endmodule

// File: tb/tb_ex_hilo_div.sv
// Scoreboard bench for ex_hilo_div: expectations are queued when an
// instruction is driven and compared mid-cycle against the DUT outputs.
`timescale 1ns/1ps
module tb_ex_hilo_div;
   import ex_hilo_div_pkg::*;

   localparam int SEL_DATA  = 0;
   localparam int SEL_WEN   = 1;
   localparam int SEL_STALL = 2;
   localparam int SEL_ADDR  = 3;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  operator;
   logic [2:0]  category;
   logic [31:0] operand1, operand2;
   logic [4:0]  input_write_addr;
   logic        input_write_enable;
   logic        flush;
   logic [4:0]  write_addr;
   logic        write_enable;
   logic [31:0] write_data;
   logic        stall_request;

   ex_hilo_div #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .OP_WIDTH(8), .CAT_WIDTH(3)) dut (
      .clock              (clock),
      .reset              (reset),
      .operator           (operator),
      .category           (category),
      .operand1           (operand1),
      .operand2           (operand2),
      .input_write_addr   (input_write_addr),
      .input_write_enable (input_write_enable),
      .flush              (flush),
      .write_addr         (write_addr),
      .write_enable       (write_enable),
      .write_data         (write_data),
      .stall_request      (stall_request)
   );

   always #5 clock = ~clock;

   logic [31:0] exp_q[$];
   int          sel_q[$];
   string       tag_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] model_hi, model_lo;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input int sel, input logic [31:0] exp, input string tag);
      sel_q.push_back(sel);
      exp_q.push_back(exp);
      tag_q.push_back(tag);
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         SEL_DATA:  return write_data;
         SEL_WEN:   return {31'b0, write_enable};
         SEL_STALL: return {31'b0, stall_request};
         default:   return {27'b0, write_addr};
      endcase
   endfunction

   // Compare everything queued for this cycle, then move to just after the next edge.
   task automatic drain();
      @(negedge clock);
      while (exp_q.size() > 0) begin
         check(tag_q.pop_front(), observe(sel_q.pop_front()), exp_q.pop_front());
      end
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [2:0] cat, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa, input logic we);
      category           = cat;
      operator           = op;
      operand1           = a;
      operand2           = b;
      input_write_addr   = wa;
      input_write_enable = we;
   endtask

   task automatic alu(input logic [2:0] cat, input logic [7:0] op, input logic [31:0] a,
                      input logic [31:0] b, input bit chk_data, input logic [31:0] exp_data,
                      input logic exp_we, input string tag);
      issue(cat, op, a, b, 5'd7, 1'b1);
      if (chk_data) expect_out(SEL_DATA, exp_data, {tag, "_data"});
      expect_out(SEL_WEN, {31'b0, exp_we}, {tag, "_wen"});
      drain();
   endtask

   task automatic read_hilo(input string tag);
      issue(CAT_MOVE, OP_MFHI, 32'h0, 32'h0, 5'd2, 1'b1);
      expect_out(SEL_DATA, model_hi, {tag, "_hi"});
      drain();
      issue(CAT_MOVE, OP_MFLO, 32'h0, 32'h0, 5'd2, 1'b1);
      expect_out(SEL_DATA, model_lo, {tag, "_lo"});
      drain();
   endtask

   task automatic run_mult(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input string tag);
      longint          ps;
      longint unsigned pu;
      issue(CAT_MULDIV, op, a, b, 5'd0, 1'b0);
      drain();
      if (op == OP_MULT) begin
         ps = longint'($signed(a)) * longint'($signed(b));
         {model_hi, model_lo} = ps;
      end else begin
         pu = {32'b0, a} * {32'b0, b};
         {model_hi, model_lo} = pu;
      end
      read_hilo(tag);
   endtask

   task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_stall, input string tag);
      int     n;
      longint da, db, q, r;
      n = 0;
      issue(CAT_MULDIV, op, a, b, 5'd6, 1'b1);
      forever begin
         @(negedge clock);
         if (!stall_request) break;
         n++;
         if (n > 100) break;
         @(posedge clock);
         #1;
      end
      check({tag, "_stall_cycles"}, n, exp_stall);
      check({tag, "_wen"}, {31'b0, write_enable}, 32'd0);
      @(posedge clock);
      #1;
      if (b == 32'h0) begin
         model_hi = 32'h0;
         model_lo = 32'h0;
      end else begin
         if (op == OP_DIV) begin
            da = longint'($signed(a));
            db = longint'($signed(b));
         end else begin
            da = longint'({32'b0, a});
            db = longint'({32'b0, b});
         end
         q = da / db;
         r = da % db;
         model_lo = q[31:0];
         model_hi = r[31:0];
      end
      read_hilo(tag);
   endtask

   // Start DIV 50/5, then in BUSY cycle 10 hit it with flush or reset.
   task automatic abort_div(input bit use_reset, input string tag);
      issue(CAT_MULDIV, OP_DIV, 32'd50, 32'd5, 5'd9, 1'b1);
      expect_out(SEL_STALL, 32'd1, {tag, "_stall_start"});
      drain();
      repeat (9) @(posedge clock);
      #1;
      expect_out(SEL_STALL, 32'd1, {tag, "_stall_busy9"});
      @(negedge clock);
      check(tag_q.pop_front(), observe(sel_q.pop_front()), exp_q.pop_front());
      @(posedge clock);
      #1;
      if (use_reset) begin
         reset = 1'b1;
         expect_out(SEL_DATA, ZERO_WORD, {tag, "_data"});
         expect_out(SEL_WEN, 32'd0, {tag, "_wen"});
         expect_out(SEL_ADDR, 32'd0, {tag, "_addr"});
         model_hi = 32'h0;
         model_lo = 32'h0;
      end else begin
         flush = 1'b1;
      end
      expect_out(SEL_STALL, 32'd0, {tag, "_stall"});
      drain();
      reset = 1'b0;
      flush = 1'b0;
      read_hilo(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      reset    = 1'b1;
      flush    = 1'b0;
      model_hi = 32'h0;
      model_lo = 32'h0;
      issue(CAT_LOGIC, OP_OR, 32'hFFFF_0000, 32'h1, 5'd9, 1'b1);
      @(posedge clock);
      #1;
      expect_out(SEL_DATA, ZERO_WORD, "rst_data");
      expect_out(SEL_WEN, 32'd0, "rst_wen");
      expect_out(SEL_ADDR, 32'd0, "rst_addr");
      expect_out(SEL_STALL, 32'd0, "rst_stall");
      drain();
      reset = 1'b0;
      read_hilo("rst");

      issue(CAT_LOGIC, OP_OR, 32'h0000_F0F0, 32'h0000_0F0F, 5'd3, 1'b1);
      expect_out(SEL_DATA, 32'h0000_FFFF, "ori_data");
      expect_out(SEL_WEN, 32'd1, "ori_wen");
      expect_out(SEL_ADDR, 32'd3, "ori_addr");
      drain();

      alu(CAT_ARITH, OP_ADD,  32'h7FFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b0, "add_ovf");
      alu(CAT_ARITH, OP_ADDU, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000, 1'b1, "addu");
      alu(CAT_ARITH, OP_SUB,  32'h8000_0000, 32'h1, 1'b0, 32'h0, 1'b0, "sub_ovf");
      alu(CAT_ARITH, OP_SUBU, 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1, "subu");
      alu(CAT_ARITH, OP_SUB,  32'h5, 32'h7, 1'b1, 32'hFFFF_FFFE, 1'b1, "sub");
      alu(CAT_ARITH, OP_SLT,  32'hFFFF_FFFF, 32'h1, 1'b1, 32'h1, 1'b1, "slt");
      alu(CAT_ARITH, OP_SLTU, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h0, 1'b1, "sltu");
      alu(CAT_SHIFT, OP_SLL,  32'h24, 32'h8000_0001, 1'b1, 32'h0000_0010, 1'b1, "sll");
      alu(CAT_SHIFT, OP_SRL,  32'h24, 32'h8000_0001, 1'b1, 32'h0800_0000, 1'b1, "srl");
      alu(CAT_SHIFT, OP_SRA,  32'h24, 32'h8000_0001, 1'b1, 32'hF800_0000, 1'b1, "sra");
      alu(CAT_LOGIC, OP_LUI,  32'h0, 32'h0000_1234, 1'b1, 32'h1234_0000, 1'b1, "lui");
      alu(CAT_LOGIC, OP_NOR,  32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1, "nor");
      alu(3'd7, OP_ADD, 32'h3, 32'h4, 1'b1, 32'h0, 1'b1, "unknown_cat");

      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom;
         alu(CAT_ARITH, OP_ADDU, ra, rb, 1'b1, ra + rb, 1'b1, "rnd_addu");
         alu(CAT_LOGIC, OP_XOR,  ra, rb, 1'b1, ra ^ rb, 1'b1, "rnd_xor");
         alu(CAT_ARITH, OP_SLTU, ra, rb, 1'b1, (ra < rb) ? 32'h1 : 32'h0, 1'b1, "rnd_sltu");
      end

      run_mult(OP_MULT,  32'hFFFF_FFFE, 32'h3, "mult");
      run_mult(OP_MULTU, 32'hFFFF_FFFE, 32'h3, "multu");
      alu(CAT_MULDIV, OP_MUL, 32'h6, 32'h7, 1'b1, 32'd42, 1'b1, "mul");
      read_hilo("mul_keeps");

      alu(CAT_MOVE, OP_MTHI, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0, 1'b0, "mthi");
      model_hi = 32'hDEAD_BEEF;
      alu(CAT_MOVE, OP_MTLO, 32'h1234_5678, 32'h0, 1'b0, 32'h0, 1'b0, "mtlo");
      model_lo = 32'h1234_5678;
      read_hilo("mt");

      run_div(OP_DIV,  32'hFFFF_FFF9, 32'd2, 33, "div_neg7_2");
      run_div(OP_DIVU, 32'd100, 32'd7, 33, "divu_100_7");
      run_div(OP_DIV,  32'd9, 32'd0, 0, "div_zero");
      run_div(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 33, "div_minint");
      run_div(OP_DIVU, 32'd100, 32'd7, 33, "divu_again");

      abort_div(1'b0, "flush");
      abort_div(1'b1, "reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_hilo_div.md
Name: ex_hilo_div

Overview:
- Next-generation execute stage of the MIPS pipeline, parametrised in data and register-address width.
- Covers logic, shift, arithmetic, multiply and divide instruction classes, plus architectural HI/LO registers.
- Includes an iterative multi-cycle divider that stalls the pipeline through stall_request.
- Sits between the ID/EX and EX/MEM pipeline registers; single-cycle ops keep the combinational EX output path.

Parameters:
- DATA_WIDTH, 32, operand/result/HI/LO width; must be even and >= 8.
- ADDR_WIDTH, 5, register-file address width.
- OP_WIDTH, 8, operator code width.
- CAT_WIDTH, 3, category code width.

Ports:
- clock  in  1  Rising-edge clock.
- reset  in  1  Synchronous, active-high reset.
- operator  in  OP_WIDTH  ALU operator code.
- category  in  CAT_WIDTH  ALU category code.
- operand1  in  DATA_WIDTH  rs value.
- operand2  in  DATA_WIDTH  rt value or extended immediate.
- input_write_addr  in  ADDR_WIDTH  Destination register.
- input_write_enable  in  1  Destination write request.
- flush  in  1  Annuls the in-flight instruction, including any divide.
- write_addr  out  ADDR_WIDTH  Passed-through destination.
- write_enable  out  1  GPR write enable.
- write_data  out  DATA_WIDTH  GPR result.
- stall_request  out  1  High while the divider holds the pipeline.

Behaviour:
- Reset and control:
  - Clock is single; reset is synchronous, active-high.
  - While reset is high: write_addr=0, write_enable=0, write_data=0, stall_request=0.
  - At the reset edge: HI=0, LO=0, divider FSM to IDLE, divider registers cleared.
  - Reset mid-divide abandons it; HI/LO are not updated.
- Single-cycle categories, combinational from inputs; HI/LO are updated at the clock edge ending the cycle:
  - LOGIC: AND, OR, XOR, NOR, LUI.
  - SHIFT: SLL, SRL, SRA; shift amount = operand1[log2(DATA_WIDTH)-1:0].
  - ARITH: ADD, ADDU, SUB, SUBU, SLT, SLTU. ADD/SUB signed overflow forces write_enable=0 (result discarded); ADDU/SUBU wrap modulo 2^DATA_WIDTH.
  - MOVE: MFHI/MFLO put HI/LO on write_data. MTHI/MTLO load operand1 into HI/LO, with write_enable=0.
  - MULDIV, multiply: MULT/MULTU form the 2*DATA_WIDTH product; {HI,LO} = product. MUL writes the low half to the GPR and leaves HI/LO unchanged.
  - Unknown category: write_data=0. write_enable follows input_write_enable except for the overflow and MT* cases above.
- Divider FSM (DIV signed, DIVU unsigned); states IDLE, BUSY, DONE:
  - IDLE: on DIV/DIVU with a nonzero divisor, assert stall_request combinationally in that cycle. At the edge, latch magnitudes and sign flags; count=0; go to BUSY.
  - BUSY: one restoring shift-subtract step per cycle; stall_request=1. After DATA_WIDTH steps go to DONE.
  - DONE: stall_request=0. Apply signs: quotient negated if operand signs differ; remainder takes the dividend's sign. At the edge LO=quotient, HI=remainder; go to IDLE unconditionally, so the held DIV is not restarted.
  - Total stall: DATA_WIDTH+1 cycles; the instruction leaves EX in the DONE cycle.
  - Divide by zero: no stall; HI=0, LO=0 at the edge.
  - Divide ops have write_enable=0.
  - flush in any state returns the FSM to IDLE, deasserts stall_request the same cycle, and suppresses the HI/LO update.
  - MTHI/MTLO/MULT cannot coincide with BUSY, because the pipeline is held.
- Signed edge case: the most-negative dividend / -1 yields LO = most-negative value, HI=0, with no exception.

Decomposition:
- Shared definitions header: operator and category codes, ENABLE/DISABLE, ZERO_WORD, and the divider state encodings. All are extended for the new ops.
- Sub-module div_unit contains the iterative divider:
  - inputs: clock, reset, start, signed_mode, dividend, divisor, annul.
  - outputs: busy, done, quotient, remainder.
- ex_hilo_div keeps the result muxes, overflow detection and the HI/LO registers.

Test Plan:
- ORI 0x0000F0F0|0x00000F0F, write_addr=3, enable=1 -> write_data=0x0000FFFF, write_enable=1, same cycle.
- ADD 0x7FFFFFFF+1 -> write_enable=0. ADDU with the same operands -> write_data=0x80000000, write_enable=1.
- MULT 0xFFFFFFFE*3 -> next cycle MFHI=0xFFFFFFFF, MFLO=0xFFFFFFFA. MULTU with the same operands -> HI=2, LO=0xFFFFFFFA.
- DIV -7/2 held under stall -> stall_request high exactly 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- DIV by 0 -> no stall, HI=LO=0. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start DIV 50/5; assert flush in BUSY cycle 10 -> stall_request=0 that cycle, HI/LO unchanged. Repeat with reset instead -> HI/LO=0, all outputs 0.
